// File: rtl/adc_cmd_arbiter_pkg.sv
// Shared definitions for the ADC command arbiter.
//   - Channel / sample widths used by the sequencer interface.
//   - Arbiter FSM state encoding and the port-id type stored in the tag FIFO.
package adc_cmd_arbiter_pkg;

  localparam int unsigned CHAN_W   = 5;
  localparam int unsigned SAMPLE_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  typedef logic port_id_t;

  // Port that owns the command channel in a given state (port 0 when idle).
  function automatic port_id_t grant_port(input arb_state_e s);
    return port_id_t'(s == ST_GRANT1);
  endfunction

endpackage

// File: rtl/adc_tag_fifo.sv
// Tag FIFO: remembers which requester issued each outstanding command so the
// matching response can be routed back in order.
// Ports:
//   clk, reset_n      clock, async active-low reset (pointers/count only)
//   i_push, i_din     write a tag (caller never pushes when full)
//   i_pop             drop the head tag (caller never pops when empty)
//   o_dout            head tag
//   o_full, o_empty   occupancy flags
module adc_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  // Storage is not reset; occupancy tracking alone defines validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/adc_cmd_arbiter.sv
// Two-requester ADC command arbiter with in-order response routing.
// Packets from two requesters are arbitrated onto one ADC command channel
// (port 0 preferred, port 1 forced after STARVE_LIMIT port-0 packets). Each
// transferred command records its port in a tag FIFO; ADC responses are routed
// combinationally to the port at the FIFO head.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   req_valid/ready/data/sop/eop    per-requester command streams
//   cmd_valid/ready/data/sop/eop    ADC command stream
//   resp_valid/data/channel/sop/eop ADC response stream (no backpressure)
//   rsp_valid/data/channel/sop/eop  routed response (one-hot valid)
//   orphan_err                      pulse: response seen with nothing outstanding
module adc_cmd_arbiter
  import adc_cmd_arbiter_pkg::*;
#(
  parameter int unsigned TAG_DEPTH    = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*CHAN_W-1:0] req_data,
  input  logic [1:0]          req_sop,
  input  logic [1:0]          req_eop,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [CHAN_W-1:0]   cmd_data,
  output logic                cmd_sop,
  output logic                cmd_eop,
  input  logic                resp_valid,
  input  logic [SAMPLE_W-1:0] resp_data,
  input  logic [CHAN_W-1:0]   resp_channel,
  input  logic                resp_sop,
  input  logic                resp_eop,
  output logic [1:0]          rsp_valid,
  output logic [SAMPLE_W-1:0] rsp_data,
  output logic [CHAN_W-1:0]   rsp_channel,
  output logic                rsp_sop,
  output logic                rsp_eop,
  output logic                orphan_err
);

  localparam int unsigned    SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_nxt;
  logic          r_orphan;

  port_id_t w_port;
  logic     w_granted;
  logic     w_xfer;
  logic     w_pick1;
  logic     w_pop;
  logic     w_tag_full;
  logic     w_tag_empty;
  port_id_t w_head;

  assign w_port    = grant_port(r_state);
  assign w_granted = (r_state != ST_IDLE);

  // Command path: granted port's fields, stalled while all tags are in use.
  assign cmd_valid = w_granted & req_valid[w_port] & ~w_tag_full;
  assign cmd_data  = w_port ? req_data[2*CHAN_W-1:CHAN_W] : req_data[CHAN_W-1:0];
  assign cmd_sop   = req_sop[w_port];
  assign cmd_eop   = req_eop[w_port];
  assign w_xfer    = cmd_valid & cmd_ready;

  always_comb begin
    req_ready = 2'b00;
    if (w_granted) req_ready[w_port] = cmd_ready & ~w_tag_full;
  end

  assign w_pick1 = req_valid[1] & ((r_starve == STARVE_MAX) | ~req_valid[0]);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (|req_valid) w_state_nxt = w_pick1 ? ST_GRANT1 : ST_GRANT0;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (w_xfer && cmd_eop) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counts finished port-0 packets that port 1 watched go by.
  always_comb begin
    w_starve_nxt = r_starve;
    if (r_state == ST_IDLE && w_state_nxt == ST_GRANT1) begin
      w_starve_nxt = '0;
    end else if (r_state == ST_GRANT0 && w_xfer && cmd_eop && req_valid[1] &&
                 r_starve != STARVE_MAX) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_orphan <= resp_valid & w_tag_empty;
    end
  end

  assign orphan_err = r_orphan;
  assign w_pop      = resp_valid & ~w_tag_empty;

  adc_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_xfer),
    .i_din   (w_port),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  // Zero-latency routing to whichever port issued the oldest outstanding command.
  always_comb begin
    rsp_valid = 2'b00;
    if (w_pop) rsp_valid[w_head] = 1'b1;
  end

  assign rsp_data    = resp_data;
  assign rsp_channel = resp_channel;
  assign rsp_sop     = resp_sop;
  assign rsp_eop     = resp_eop;

endmodule

// File: tb/tb_adc_cmd_arbiter.sv
// Randomized bench for adc_cmd_arbiter: two packet sources, random ADC
// readiness and responses, checked each cycle against a transaction-level model
// (current owner, outstanding-tag queue, starvation count).
module tb_adc_cmd_arbiter;

  localparam int DEPTH = 8;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_sop, req_eop;
  logic [9:0]  req_data;
  logic        cmd_valid, cmd_ready, cmd_sop, cmd_eop;
  logic [4:0]  cmd_data;
  logic        resp_valid, resp_sop, resp_eop;
  logic [11:0] resp_data;
  logic [4:0]  resp_channel;
  logic [1:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic [4:0]  rsp_channel;
  logic        rsp_sop, rsp_eop, orphan_err;

  adc_cmd_arbiter #(
    .TAG_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_sop      (req_sop),
    .req_eop      (req_eop),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .cmd_sop      (cmd_sop),
    .cmd_eop      (cmd_eop),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_channel (resp_channel),
    .resp_sop     (resp_sop),
    .resp_eop     (resp_eop),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_channel  (rsp_channel),
    .rsp_sop      (rsp_sop),
    .rsp_eop      (rsp_eop),
    .orphan_err   (orphan_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the channel (-1 = nobody), outstanding tags in
  // issue order, port-0 packets completed while port 1 waited.
  int m_owner;
  int m_starve;
  bit m_tags[$];
  bit m_orphan;

  // Packet sources.
  int pkt_len[2];
  int pkt_idx[2];
  int pkt_ch[2][4];

  int n_xfer  = 0;
  int n_grant1 = 0;

  function automatic void model_reset();
    m_owner  = -1;
    m_starve = 0;
    m_tags.delete();
    m_orphan = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pkt_len[p] = 0;
      pkt_idx[p] = 0;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    req_valid  = 2'b11;
    cmd_ready  = 1'b1;
    resp_valid = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_orphan",    32'(orphan_err), 32'd0);
    req_valid  = 2'b00;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input int valid_pct, input int ready_pct, input int resp_pct);
    logic [1:0] rv;
    logic [4:0] ch [2];
    logic [1:0] sop, eop;
    bit         full, empty, exp_cv, xfer, pick1;
    logic [1:0] exp_rdy, exp_rsp;
    int         p;

    @(negedge clk);
    reset_n = 1'b1;
    for (int q = 0; q < 2; q++) begin
      if (pkt_len[q] == 0 && $urandom_range(0, 99) < 40) begin
        pkt_len[q] = int'($urandom_range(1, 4));
        pkt_idx[q] = 0;
        for (int k = 0; k < 4; k++) pkt_ch[q][k] = int'($urandom_range(0, 31));
      end
      rv[q] = (pkt_len[q] != 0) && ($urandom_range(0, 99) < valid_pct);
      if (pkt_len[q] != 0) begin
        ch[q]  = 5'(pkt_ch[q][pkt_idx[q]]);
        sop[q] = (pkt_idx[q] == 0);
        eop[q] = (pkt_idx[q] == pkt_len[q] - 1);
      end else begin
        ch[q]  = 5'($urandom);
        sop[q] = 1'($urandom);
        eop[q] = 1'($urandom);
      end
    end
    req_valid    = rv;
    req_data     = {ch[1], ch[0]};
    req_sop      = sop;
    req_eop      = eop;
    cmd_ready    = ($urandom_range(0, 99) < ready_pct);
    resp_valid   = ($urandom_range(0, 99) < resp_pct);
    resp_data    = 12'($urandom);
    resp_channel = 5'($urandom);
    resp_sop     = 1'($urandom);
    resp_eop     = 1'($urandom);
    #1;

    full    = (m_tags.size() == DEPTH);
    empty   = (m_tags.size() == 0);
    exp_cv  = 1'b0;
    exp_rdy = 2'b00;
    p       = (m_owner < 0) ? 0 : m_owner;
    if (m_owner >= 0) begin
      exp_cv     = rv[p] && !full;
      exp_rdy[p] = cmd_ready && !full;
    end
    check_eq("cmd_valid", 32'(cmd_valid), 32'(exp_cv));
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_cv) begin
      check_eq("cmd_data", 32'(cmd_data), 32'(ch[p]));
      check_eq("cmd_sop_eop", 32'({cmd_sop, cmd_eop}), 32'({sop[p], eop[p]}));
    end
    exp_rsp = 2'b00;
    if (resp_valid && !empty) exp_rsp = m_tags[0] ? 2'b10 : 2'b01;
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    check_eq("rsp_data", 32'(rsp_data), 32'(resp_data));
    check_eq("rsp_chan_sop_eop", 32'({rsp_channel, rsp_sop, rsp_eop}),
             32'({resp_channel, resp_sop, resp_eop}));
    check_eq("orphan_err", 32'(orphan_err), 32'(m_orphan));

    // Advance the model to what the next clock edge should produce.
    xfer = exp_cv && cmd_ready;
    if (resp_valid && !empty) void'(m_tags.pop_front());
    m_orphan = resp_valid && empty;
    if (m_owner < 0) begin
      if (rv != 2'b00) begin
        pick1 = rv[1] && (m_starve == LIMIT || !rv[0]);
        if (pick1) begin
          m_starve = 0;
          m_owner  = 1;
          n_grant1++;
        end else begin
          m_owner = 0;
        end
      end
    end else if (xfer) begin
      m_tags.push_back(bit'(p));
      n_xfer++;
      pkt_idx[p]++;
      if (pkt_idx[p] == pkt_len[p]) pkt_len[p] = 0;
      if (eop[p]) begin
        if (p == 0 && rv[1] && m_starve < LIMIT) m_starve++;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = 2'b00;
    req_data     = '0;
    req_sop      = 2'b00;
    req_eop      = 2'b00;
    cmd_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_data    = '0;
    resp_channel = '0;
    resp_sop     = 1'b0;
    resp_eop     = 1'b0;
    model_reset();
    do_reset();

    // Slow responses: tag FIFO fills and holds commands back.
    for (int i = 0; i < 1200; i++) cycle(90, 90, 6);
    // Reset wherever the traffic happens to be, then keep going.
    do_reset();
    // Heavy contention with moderate response rate.
    for (int i = 0; i < 1500; i++) cycle(100, 85, 45);
    do_reset();
    // Response-heavy: plenty of orphan responses and gapped requests.
    for (int i = 0; i < 1200; i++) cycle(60, 70, 70);

    $display("transfers=%0d port1_grants=%0d", n_xfer, n_grant1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/adc_cmd_arbiter.md
ADC_CMD_ARBITER -- requirements
Module: adc_cmd_arbiter

Interface
REQ-001 Parameter TAG_DEPTH, 8, max outstanding commands awaiting response (power of 2, 2..32).
REQ-002 Parameter STARVE_LIMIT, 4, consecutive port-0 packets granted while port 1 waits before port 1 is forced.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  2  per-requester command valid; bit n = port n.
REQ-006 req_ready  out  2  per-requester command ready.
REQ-007 req_data  in  10  command channel numbers; [4:0] port 0, [9:5] port 1.
REQ-008 req_sop  in  2  per-requester start of packet.
REQ-009 req_eop  in  2  per-requester end of packet.
REQ-010 cmd_valid  out  1  ADC command valid.
REQ-011 cmd_ready  in  1  ADC command ready.
REQ-012 cmd_data  out  5  ADC command channel.
REQ-013 cmd_sop  out  1  ADC command start of packet.
REQ-014 cmd_eop  out  1  ADC command end of packet.
REQ-015 resp_valid  in  1  ADC response valid; no backpressure.
REQ-016 resp_data  in  12  ADC sample.
REQ-017 resp_channel  in  5  ADC response channel.
REQ-018 resp_sop  in  1  ADC response start of packet.
REQ-019 resp_eop  in  1  ADC response end of packet.
REQ-020 rsp_valid  out  2  one-hot routed response valid; bit n = port n.
REQ-021 rsp_data  out  12  routed sample, shared by both ports.
REQ-022 rsp_channel  out  5  routed channel, shared.
REQ-023 rsp_sop  out  1  routed start of packet, shared.
REQ-024 rsp_eop  out  1  routed end of packet, shared.
REQ-025 orphan_err  out  1  one-cycle pulse: response arrived with no outstanding command.

Function
REQ-026 FSM states IDLE, GRANT0, GRANT1; IDLE with any req_valid moves to GRANTn next cycle (one bubble cycle per packet).
REQ-027 IDLE choice: port 1 if req_valid[1] and (starve_cnt == STARVE_LIMIT or req_valid[0]==0); else port 0.
REQ-028 In GRANTn: cmd_valid = req_valid[n] & ~tag_full; req_ready[n] = cmd_ready & ~tag_full; other port's ready 0; cmd_data/sop/eop = port n fields.
REQ-029 In IDLE: cmd_valid 0, req_ready 0.
REQ-030 Transfer = cmd_valid & cmd_ready; transfer with cmd_eop returns FSM to IDLE; grant held across gaps in req_valid until eop.
REQ-031 starve_cnt (saturating at STARVE_LIMIT): +1 on port-0 eop transfer while req_valid[1]=1; cleared on entering GRANT1.
REQ-032 Tag FIFO, TAG_DEPTH x 1 bit: push granted port id on every transfer; pop on every resp_valid with FIFO non-empty; simultaneous push/pop keeps count.
REQ-033 tag_full holds commands (cmd_valid 0) until a pop; push never occurs when full.
REQ-034 Routing zero-latency combinational: rsp_valid[head]=resp_valid when non-empty; rsp_data/channel/sop/eop = resp_* directly.
REQ-035 resp_valid with FIFO empty: rsp_valid 00, no pop, orphan_err=1 the following cycle only.

Reset
REQ-036 Asserting reset_n low, including mid-packet, forces IDLE, starve_cnt 0, FIFO empty, orphan_err 0; outputs req_ready 00, cmd_valid 0, rsp_valid 00.
REQ-037 FIFO storage needs no reset; only pointers/count reset.

Structure
REQ-038 Shared package holds FSM state enum, port-id type, and 5-bit channel / 12-bit sample width constants used with the sequencer.
REQ-039 Tag FIFO is one sub-module, adc_tag_fifo (parameterised depth/width, push/pop/full/empty).

Verification
REQ-040 Port 0 sends 3-cmd packet ch {2,5,7}, ready=1 -> cmd_data 2,5,7 on cycles 2-4 after request, sop on 2, eop on 7, FSM back to IDLE.
REQ-041 Both ports request continuously, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1.
REQ-042 TAG_DEPTH=8, no responses, 10 commands offered -> exactly 8 transfers, cmd_valid 0 after; one response -> one more transfer.
REQ-043 Port 0 cmds ch 1,2 then port 1 ch 3; 3 responses -> rsp_valid 01,01,10 with resp_data passed through in the same cycle.
REQ-044 resp_valid with empty FIFO -> rsp_valid 00, orphan_err high exactly one cycle later, count still 0.
REQ-045 reset_n low mid-packet after 1 of 3 transfers -> IDLE, req_ready 00, FIFO empty; later responses flag orphan_err.
